count_ah: RTL and testbench
===========================

COUNT_AH -- requirements
Module: count_ah

Interface
REQ-001 Parameter WIDTH, default 9: bit width of the shift-register counter.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  one clock; reset is asynchronous and active-high.
REQ-004 mode  input  2  operation select: HOLD=2'b00, LEFT=2'b01, RIGHT=2'b10, PLOAD=2'b11.
REQ-005 parallelIn  input  WIDTH  parallel load value.
REQ-006 serialIn  input  1  bit shifted into the vacated end on LEFT/RIGHT.
REQ-007 parallelOut  output  WIDTH  current register contents, driven directly from the state flops.

Function
REQ-008 The block SHALL hold a WIDTH-bit register Q, with parallelOut = Q at all times.
REQ-009 On each rising clk edge with reset low, the block SHALL update Q according to the mode sampled on that edge.
REQ-010 HOLD: Q SHALL be unchanged.
REQ-011 LEFT: Q SHALL become {Q[WIDTH-2:0], serialIn}; the MSB is discarded.
REQ-012 RIGHT: Q SHALL become {serialIn, Q[WIDTH-1:1]}; the LSB is discarded.
REQ-013 PLOAD: Q SHALL become parallelIn.
REQ-014 Latency: the new Q SHALL appear on parallelOut immediately after the edge; there is no extra pipeline stage.
REQ-015 One-hot counting: after PLOAD of 1 followed by N LEFT edges with serialIn=0, Q SHALL equal 1<<N; bit WIDTH-1 is first set after WIDTH-1 LEFT edges (8 for WIDTH=9); this bit is the terminal-count flag for callers.
REQ-016 Wrap-around: no wrap occurs; a further LEFT edge with serialIn=0 SHALL shift the 1 out and yield Q=0.
REQ-017 Mode changes SHALL take effect on the next edge with no handshake; any mode sequence is legal.
REQ-018 Mode is a 2-bit encoding, so every value is defined; no illegal-value handling is required.

Reset
REQ-019 While reset is high, Q SHALL be forced to all zeros asynchronously, independent of clk.
REQ-020 Reset asserted mid-shift SHALL discard in-progress contents; after release, the first rising edge with reset low SHALL apply the mode normally.
REQ-021 When reset and a clk edge occur together, reset SHALL win and Q SHALL remain 0.

Structure
REQ-022 The mode encodings HOLD/LEFT/RIGHT/PLOAD SHALL live in a shared package, count_modes_pkg, used by count_ah and its callers.
REQ-023 The state SHALL be held in one sub-module, register_dff_para.
REQ-024 register_dff_para ports: q (WIDTH output), d (WIDTH input), wrenable, clk, reset.
REQ-025 register_dff_para SHALL load d into q on a rising clk edge when wrenable=1, hold otherwise, and clear asynchronously on reset.
REQ-026 The next-state logic in count_ah SHALL be a combinational 4-way mux on mode; count_ah SHALL drive wrenable=1.

Verification
REQ-027 WIDTH=9: reset pulse -> parallelOut=9'h000 immediately, before any clk edge.
REQ-028 PLOAD parallelIn=9'h001, then 8 LEFT edges, serialIn=0 -> parallelOut=9'h100 exactly on the 8th edge, bit8=0 on all prior edges; one more LEFT edge -> 9'h000.
REQ-029 PLOAD 9'h0A5, then 3 HOLD edges -> 9'h0A5 unchanged; then 1 RIGHT edge, serialIn=1 -> 9'h152.
REQ-030 From 9'h000, 9 LEFT edges with serialIn=1 -> 9'h1FF; then 1 PLOAD with parallelIn=9'h001 -> 9'h001.
REQ-031 PLOAD 9'h001, 4 LEFT edges (9'h010), assert reset between edges -> 9'h000 without a clk edge; release reset, apply LEFT -> 9'h000 (serialIn=0).
REQ-032 Reset held high across a PLOAD edge with parallelIn=9'h1FF -> parallelOut stays 9'h000.

Source files
------------

// File: rtl/count_modes_pkg.sv
// Shared mode encodings for the count_ah shift-register counter and its callers.
package count_modes_pkg;

   localparam int COUNT_WIDTH_DEFAULT = 9;

   typedef enum logic [1:0] {
      MODE_HOLD  = 2'b00,
      MODE_LEFT  = 2'b01,
      MODE_RIGHT = 2'b10,
      MODE_PLOAD = 2'b11
   } mode_e;

endpackage : count_modes_pkg

// File: rtl/register_dff_para.sv
// WIDTH-bit parallel register with write enable and asynchronous active-high clear.
module register_dff_para #(
   parameter int WIDTH = 9
) (
   output logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] d,
   input  logic             wrenable,
   input  logic             clk,
   input  logic             reset
);

   logic [WIDTH-1:0] reg_d;
   logic [WIDTH-1:0] reg_q;

   // Load d when enabled, otherwise recirculate the stored value.
   always_comb begin
      reg_d = wrenable ? d : reg_q;
   end

   // State flops; reset clears immediately without waiting for clk.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reg_q <= '0;
      end else begin
         reg_q <= reg_d;
      end
   end

   assign q = reg_q;

endmodule : register_dff_para

// File: rtl/count_ah.sv
// Shift-register counter: hold, shift left/right with serial fill, or parallel load.
// A one-hot 1 shifted left reaches the MSB after WIDTH-1 edges; callers use that bit
// as a terminal-count flag. The output comes straight off the state flops.
module count_ah
   import count_modes_pkg::*;
#(
   parameter int WIDTH = COUNT_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] parallelIn,
   input  logic             serialIn,
   output logic [WIDTH-1:0] parallelOut
);

   logic [WIDTH-1:0] cnt_d;
   logic [WIDTH-1:0] cnt_q;

   // Next-state select: four-way mux on the sampled mode.
   always_comb begin
      cnt_d = cnt_q;
      case (mode_e'(mode))
         MODE_HOLD:  cnt_d = cnt_q;
         MODE_LEFT:  cnt_d = {cnt_q[WIDTH-2:0], serialIn};
         MODE_RIGHT: cnt_d = {serialIn, cnt_q[WIDTH-1:1]};
         MODE_PLOAD: cnt_d = parallelIn;
         default:    cnt_d = cnt_q;
      endcase
   end

   // The register is written every edge; HOLD is expressed by recirculating in the mux.
   register_dff_para #(
      .WIDTH (WIDTH)
   ) u_state (
      .q        (cnt_q),
      .d        (cnt_d),
      .wrenable (1'b1),
      .clk      (clk),
      .reset    (reset)
   );

   assign parallelOut = cnt_q;

endmodule : count_ah

// File: tb/tb_count_ah.sv
// Self-checking bench for count_ah (WIDTH=9): directed scenarios plus randomized
// mode/data sequences against an arithmetic reference model.
module tb_count_ah;

   localparam int W = 9;
   localparam int unsigned MODV = 1 << W;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [1:0]   mode = 2'b00;
   logic [W-1:0] parallelIn = '0;
   logic         serialIn = 1'b0;
   logic [W-1:0] parallelOut;

   int unsigned model;
   int checks = 0;
   int errors = 0;

   count_ah #(.WIDTH(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .mode        (mode),
      .parallelIn  (parallelIn),
      .serialIn    (serialIn),
      .parallelOut (parallelOut)
   );

   always #5 clk = ~clk;

   // Register value viewed as a number modulo 2^W.
   function automatic int unsigned ref_next(input int unsigned cur, input logic [1:0] m,
                                            input logic [W-1:0] p, input logic s);
      case (m)
         2'b00:   return cur;
         2'b01:   return (cur * 2 + int'(s)) % MODV;
         2'b10:   return cur / 2 + int'(s) * (MODV / 2);
         default: return int'(p);
      endcase
   endfunction

   task automatic drive_edge(input logic [1:0] m, input logic [W-1:0] p, input logic s);
      @(negedge clk);
      mode = m;
      parallelIn = p;
      serialIn = s;
      @(posedge clk);
      #1;
      if (reset) model = 0;
      else model = ref_next(model, m, p, s);
   endtask

   task automatic test_reset;
      #1 reset = 1'b1;
      #2;
      checks++;
      if (parallelOut !== 9'h000) begin
         errors++;
         $display("FAIL reset_no_edge got %h want %h", parallelOut, 9'h000);
      end
      @(negedge clk);
      reset = 1'b0;
      model = 0;
   endtask

   task automatic test_onehot;
      drive_edge(2'b11, 9'h001, 1'b0);
      checks++;
      if (parallelOut !== 9'h001) begin
         errors++;
         $display("FAIL onehot_load got %h want %h", parallelOut, 9'h001);
      end
      for (int i = 1; i <= 8; i++) begin
         drive_edge(2'b01, 9'h1FF, 1'b0);
         checks++;
         if (parallelOut !== W'(1 << i)) begin
            errors++;
            $display("FAIL onehot_shift%0d got %h want %h", i, parallelOut, W'(1 << i));
         end
      end
      drive_edge(2'b01, 9'h000, 1'b0);
      checks++;
      if (parallelOut !== 9'h000) begin
         errors++;
         $display("FAIL onehot_shiftout got %h want %h", parallelOut, 9'h000);
      end
   endtask

   task automatic test_hold_right;
      drive_edge(2'b11, 9'h0A5, 1'b0);
      for (int i = 0; i < 3; i++) begin
         drive_edge(2'b00, 9'h1FF, 1'b1);
         checks++;
         if (parallelOut !== 9'h0A5) begin
            errors++;
            $display("FAIL hold%0d got %h want %h", i, parallelOut, 9'h0A5);
         end
      end
      drive_edge(2'b10, 9'h000, 1'b1);
      checks++;
      if (parallelOut !== 9'h152) begin
         errors++;
         $display("FAIL right_fill got %h want %h", parallelOut, 9'h152);
      end
   endtask

   task automatic test_fill_load;
      drive_edge(2'b11, 9'h000, 1'b0);
      for (int i = 0; i < 9; i++) drive_edge(2'b01, 9'h000, 1'b1);
      checks++;
      if (parallelOut !== 9'h1FF) begin
         errors++;
         $display("FAIL left_fill got %h want %h", parallelOut, 9'h1FF);
      end
      drive_edge(2'b11, 9'h001, 1'b0);
      checks++;
      if (parallelOut !== 9'h001) begin
         errors++;
         $display("FAIL reload got %h want %h", parallelOut, 9'h001);
      end
   endtask

   task automatic test_reset_mid;
      drive_edge(2'b11, 9'h001, 1'b0);
      for (int i = 0; i < 4; i++) drive_edge(2'b01, 9'h000, 1'b0);
      checks++;
      if (parallelOut !== 9'h010) begin
         errors++;
         $display("FAIL mid_before got %h want %h", parallelOut, 9'h010);
      end
      #1 reset = 1'b1;
      #1;
      checks++;
      if (parallelOut !== 9'h000) begin
         errors++;
         $display("FAIL mid_async got %h want %h", parallelOut, 9'h000);
      end
      #1 reset = 1'b0;
      model = 0;
      drive_edge(2'b01, 9'h000, 1'b0);
      checks++;
      if (parallelOut !== 9'h000) begin
         errors++;
         $display("FAIL mid_after got %h want %h", parallelOut, 9'h000);
      end
   endtask

   task automatic test_reset_over_edge;
      drive_edge(2'b11, 9'h0F0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      drive_edge(2'b11, 9'h1FF, 1'b1);
      checks++;
      if (parallelOut !== 9'h000) begin
         errors++;
         $display("FAIL reset_wins got %h want %h", parallelOut, 9'h000);
      end
      @(negedge clk);
      reset = 1'b0;
      model = 0;
      drive_edge(2'b11, 9'h0C3, 1'b0);
      checks++;
      if (parallelOut !== 9'h0C3) begin
         errors++;
         $display("FAIL post_reset_load got %h want %h", parallelOut, 9'h0C3);
      end
   endtask

   task automatic test_random;
      logic [1:0]   m;
      logic [W-1:0] p;
      logic         s;
      for (int i = 0; i < 300; i++) begin
         m = 2'($urandom_range(0, 3));
         p = W'($urandom);
         s = 1'($urandom);
         drive_edge(m, p, s);
         checks++;
         if (parallelOut !== W'(model)) begin
            errors++;
            $display("FAIL random%0d mode %b got %h want %h", i, m, parallelOut, W'(model));
         end
         if ($urandom_range(0, 19) == 0) begin
            #1 reset = 1'b1;
            #1;
            model = 0;
            checks++;
            if (parallelOut !== 9'h000) begin
               errors++;
               $display("FAIL random_reset%0d got %h want %h", i, parallelOut, 9'h000);
            end
            #1 reset = 1'b0;
         end
      end
   endtask

   initial begin
      model = 0;
      test_reset;
      test_onehot;
      test_hold_right;
      test_fill_load;
      test_reset_mid;
      test_reset_over_edge;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_count_ah
